// File: rtl/dif_radix2_64p_tm_seq_pkg.sv
// dif_radix2_64p_tm_seq_pkg: shared constants and index-to-control mapping for the 64-point tm sequencer.
// Revision: 1.0
`default_nettype none
package dif_radix2_64p_tm_seq_pkg;
  localparam int TM_CTRL_W = 6;
  localparam int FRAME_LEN = 64;
  localparam int IDX_W     = 6;

  // Row-major keeps {s[5:3],s[2:0]}; column-major swaps the two 3-bit digits.
  function automatic logic [TM_CTRL_W-1:0] idx_to_ctrl(input logic [IDX_W-1:0] idx,
                                                       input bit col_major);
    return col_major ? {idx[2:0], idx[5:3]} : idx;
  endfunction
endpackage
`default_nettype wire

// File: rtl/dif_radix2_64p_tm_vpipe.sv
// dif_radix2_64p_tm_vpipe: 2-stage enabled tag shift register tracking the tm's internal registers.
// Revision: 1.0
`default_nettype none
module dif_radix2_64p_tm_vpipe #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1 <= '0;
      q      <= '0;
    end else if (en) begin
      stage1 <= d;
      q      <= stage1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/dif_radix2_64p_tm_seq.sv
// dif_radix2_64p_tm_seq: frame-position sequencer feeding the 64-point twiddle multiplier.
// Revision: 1.0
`default_nettype none
module dif_radix2_64p_tm_seq
  import dif_radix2_64p_tm_seq_pkg::*;
#(
  parameter int DATA_WIDTH   = 10,
  parameter bit COL_MAJOR    = 1'b0,
  parameter bit SOP_REQUIRED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sop,
  input  logic [DATA_WIDTH-1:0] din_real,
  input  logic [DATA_WIDTH-1:0] din_imag,
  output logic                  tm_en,
  output logic [TM_CTRL_W-1:0]  tm_ctrl,
  output logic [DATA_WIDTH-1:0] tm_din_real,
  output logic [DATA_WIDTH-1:0] tm_din_imag,
  input  logic [DATA_WIDTH:0]   tm_dout_real,
  input  logic [DATA_WIDTH:0]   tm_dout_imag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [DATA_WIDTH:0]   dout_real,
  output logic [DATA_WIDTH:0]   dout_imag,
  output logic                  frame_err,
  output logic [7:0]            frame_cnt
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] eff_idx;
  logic             accept;
  logic             resync;
  logic             drop;
  logic             fwd;
  logic [2:0]       tag_in;
  logic [2:0]       tag_out;

  // The whole chain advances together; only a held output can stall it.
  assign tm_en    = ~(out_valid & ~out_ready);
  assign in_ready = tm_en;
  assign accept   = in_valid & tm_en;

  assign eff_idx = (in_valid && in_sop) ? '0 : idx;
  assign resync  = accept & in_sop & (idx != '0);
  assign drop    = SOP_REQUIRED & accept & ~in_sop & (idx == '0);
  assign fwd     = accept & ~drop;

  assign tm_ctrl     = idx_to_ctrl(eff_idx, COL_MAJOR);
  assign tm_din_real = fwd ? din_real : '0;
  assign tm_din_imag = fwd ? din_imag : '0;

  assign tag_in = {fwd, fwd & (eff_idx == '0), fwd & (eff_idx == LAST_IDX)};

  dif_radix2_64p_tm_vpipe #(.WIDTH(3)) u_vpipe (
    .clk (clk),
    .rst (rst),
    .en  (tm_en),
    .d   (tag_in),
    .q   (tag_out)
  );

  assign {out_valid, out_sop, out_eop} = tag_out;
  assign dout_real = tm_dout_real;
  assign dout_imag = tm_dout_imag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      frame_err <= resync | drop;
      if (fwd)
        idx <= eff_idx + 1'b1;
      if (out_valid & out_ready & out_eop)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dif_radix2_64p_tm_seq.sv
// tb_dif_radix2_64p_tm_seq: directed bench with a behavioural 2-register tm and an output scoreboard.
// Revision: 1.0
`default_nettype none
module tb_dif_radix2_64p_tm_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_sop, out_ready;
  logic [9:0]  din_real, din_imag;
  logic        in_ready, tm_en, out_valid, out_sop, out_eop, frame_err;
  logic [5:0]  tm_ctrl;
  logic [9:0]  tm_din_real, tm_din_imag;
  logic [10:0] tm_dout_real, tm_dout_imag, dout_real, dout_imag;
  logic [7:0]  frame_cnt;

  logic        cm_in_ready, cm_tm_en, cm_out_valid, cm_out_sop, cm_out_eop, cm_frame_err;
  logic [5:0]  cm_tm_ctrl;
  logic [9:0]  cm_tm_din_real, cm_tm_din_imag;
  logic [10:0] cm_dout_real, cm_dout_imag;
  logic [10:0] zero11 = '0;
  logic [7:0]  cm_frame_cnt;

  always #5 clk = ~clk;

  dif_radix2_64p_tm_seq #(.DATA_WIDTH(10), .COL_MAJOR(1'b0), .SOP_REQUIRED(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
    .din_real(din_real), .din_imag(din_imag), .tm_en(tm_en), .tm_ctrl(tm_ctrl),
    .tm_din_real(tm_din_real), .tm_din_imag(tm_din_imag),
    .tm_dout_real(tm_dout_real), .tm_dout_imag(tm_dout_imag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .dout_real(dout_real), .dout_imag(dout_imag), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  // Column-major twin on the same stimulus; only its control mapping is observed.
  dif_radix2_64p_tm_seq #(.DATA_WIDTH(10), .COL_MAJOR(1'b1), .SOP_REQUIRED(1'b1)) dut_cm (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(cm_in_ready), .in_sop(in_sop),
    .din_real(din_real), .din_imag(din_imag), .tm_en(cm_tm_en), .tm_ctrl(cm_tm_ctrl),
    .tm_din_real(cm_tm_din_real), .tm_din_imag(cm_tm_din_imag),
    .tm_dout_real(zero11), .tm_dout_imag(zero11),
    .out_valid(cm_out_valid), .out_ready(out_ready), .out_sop(cm_out_sop), .out_eop(cm_out_eop),
    .dout_real(cm_dout_real), .dout_imag(cm_dout_imag), .frame_err(cm_frame_err),
    .frame_cnt(cm_frame_cnt)
  );

  // Bench tm: two enabled registers; imag output offset by the control code to expose ctrl/data alignment.
  logic [9:0] m_r1, m_i1;
  logic [5:0] m_c1;
  always @(posedge clk) begin
    if (tm_en) begin
      m_r1         <= tm_din_real;
      m_i1         <= tm_din_imag;
      m_c1         <= tm_ctrl;
      tm_dout_real <= {m_r1[9], m_r1};
      tm_dout_imag <= {m_i1[9], m_i1} + {5'b0, m_c1};
    end
  end

  typedef struct packed {
    logic [10:0] re;
    logic [10:0] im;
    logic        sop;
    logic        eop;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         k = 0;
  int         exp_frames = 0;
  logic [5:0] m_idx = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("dout_real", dout_real, mon_e.re);
        chk("dout_imag", dout_imag, mon_e.im);
        chk("out_sop", out_sop, mon_e.sop);
        chk("out_eop", out_eop, mon_e.eop);
        if (mon_e.eop) exp_frames++;
      end
    end
  end

  // Drives one beat (v=0 gives a bubble), checks the control/data presented to the tm, scores the output.
  task automatic beat(input logic v, input logic sop);
    logic [9:0] r, i;
    logic [5:0] eff;
    logic       drop, fwd, err;
    exp_t       e;
    int         n;
    r = 10'(k * 37 + 5);
    i = 10'(k * 11 + 300);
    k++;
    in_valid = v; in_sop = sop; din_real = r; din_imag = i;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("in_ready", in_ready, 1);
    eff  = (v && sop) ? 6'd0 : m_idx;
    drop = v && !sop && (m_idx == 6'd0);
    fwd  = v && !drop;
    err  = drop || (v && sop && m_idx != 6'd0);
    chk("tm_ctrl", tm_ctrl, eff);
    chk("tm_ctrl_colmajor", cm_tm_ctrl, {eff[2:0], eff[5:3]});
    chk("tm_din_real", tm_din_real, fwd ? r : 10'd0);
    if (fwd) begin
      e.re  = {r[9], r};
      e.im  = {i[9], i} + {5'b0, eff};
      e.sop = (eff == 6'd0);
      e.eop = (eff == 6'd63);
      sbq.push_back(e);
      m_idx = eff + 6'd1;
    end
    @(posedge clk); #1;
    chk("frame_err", frame_err, err);
    in_valid = 1'b0; in_sop = 1'b0;
  endtask

  task automatic stall5();
    logic [10:0] sr;
    logic        ss, se;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("stall_valid", out_valid, 1);
    sr = dout_real; ss = out_sop; se = out_eop;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_tm_en", tm_en, 0);
      chk("stall_dout", dout_real, sr);
      chk("stall_tags", {out_valid, out_sop, out_eop}, {1'b1, ss, se});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0; in_sop = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin @(posedge clk); n++; end
    chk("drain_empty", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; out_ready = 1'b1;
    din_real = '0; din_imag = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_tags", {out_sop, out_eop, frame_err}, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Frame 1: latency, bubbles, a 5-cycle stall, then straight to index 63.
    beat(1'b1, 1'b1);
    chk("latency_t1", out_valid, 0);
    beat(1'b1, 1'b0);
    chk("latency_t2", out_valid, 1);
    chk("first_sop", out_sop, 1);
    for (int j = 0; j < 10; j++) begin
      beat(1'b1, 1'b0);
      beat(1'b0, 1'b0);
    end
    stall5();
    while (m_idx != 6'd0) beat(1'b1, 1'b0);
    drain();
    chk("frame_cnt_1", frame_cnt, exp_frames);
    chk("frames_seen_1", exp_frames, 1);

    // Frame 2: resync at index 17 restarts the count.
    beat(1'b1, 1'b1);
    repeat (16) beat(1'b1, 1'b0);
    chk("idx_before_resync", m_idx, 17);
    beat(1'b1, 1'b1);
    while (m_idx != 6'd0) beat(1'b1, 1'b0);
    drain();
    chk("frame_cnt_2", frame_cnt, exp_frames);

    // Index 0 without sop is consumed but dropped.
    beat(1'b1, 1'b0);
    drain();
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);

    // Asynchronous reset with two beats in flight.
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_cnt", frame_cnt, 0);
    sbq.delete();
    m_idx = '0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_err", frame_err, 0);
    beat(1'b1, 1'b1);
    repeat (3) beat(1'b1, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
